// File: rtl/crossbar_pipelined_stat.sv
// Router crossbar: one-hot grant switching, optional per-output register pipeline with stall,
// sticky conflict/overrun flags and saturating per-output flit counters.
module crossbar_pipelined_stat #(
    parameter int P           = 5,
    parameter int V           = 4,
    parameter int Fpay        = 32,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 16,
    localparam int Fw         = 2 + V + Fpay,
    localparam int SELW       = (P > 1) ? $clog2(P) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [P*(P-1)-1:0]   granted_dest_port_all,
    input  logic [P*Fw-1:0]      flit_in_all,
    input  logic [P-1:0]         out_stall,
    output logic [P*Fw-1:0]      flit_out_all,
    output logic [P-1:0]         flit_out_we_all,
    output logic [P-1:0]         conflict_err,
    output logic [P-1:0]         overrun_err,
    input  logic                 err_clr,
    input  logic [SELW-1:0]      cnt_sel,
    output logic [CNT_W-1:0]     cnt_out,
    input  logic                 cnt_clr
);

    logic [P-1:0]    src_m [P];
    logic [P-1:0]    req;
    logic [P-1:0]    multi;
    logic [Fw-1:0]   sel_flit [P];
    logic [P-1:0]    overrun_ev;

    logic [P-1:0]    conflict_q, conflict_d;
    logic [P-1:0]    overrun_q, overrun_d;
    logic [CNT_W-1:0] cnt_q [P];
    logic [CNT_W-1:0] cnt_d [P];

    // src_m[i][j]: input j targets output i (grant bit skips the input's own port)
    always_comb begin
        for (int i = 0; i < P; i++) begin
            src_m[i]    = '0;
            sel_flit[i] = '0;
            for (int j = 0; j < P; j++) begin
                if (j != i) begin
                    src_m[i][j] = granted_dest_port_all[j*(P-1) + ((i < j) ? i : i - 1)];
                end
            end
        end
        for (int i = 0; i < P; i++) begin
            req[i]   = |src_m[i];
            multi[i] = (src_m[i] & (src_m[i] - P'(1))) != '0;
            for (int j = P - 1; j >= 0; j--) begin
                if (src_m[i][j]) sel_flit[i] = flit_in_all[j*Fw +: Fw];
            end
        end
    end

    if (PIPE_STAGES == 0) begin : g_comb
        for (genvar i = 0; i < P; i++) begin : g_lane
            assign flit_out_all[i*Fw +: Fw] = sel_flit[i];
        end
        assign flit_out_we_all = req;
        assign overrun_ev      = '0;
    end else begin : g_pipe
        logic [PIPE_STAGES-1:0] vld_q [P];
        logic [Fw-1:0]          dat_q [P][PIPE_STAGES];

        // A stalled lane freezes every stage; data registers only load behind a valid flit
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < P; i++) begin
                    vld_q[i] <= '0;
                    for (int s = 0; s < PIPE_STAGES; s++) dat_q[i][s] <= '0;
                end
            end else begin
                for (int i = 0; i < P; i++) begin
                    if (!out_stall[i]) begin
                        vld_q[i][0] <= req[i];
                        if (req[i]) dat_q[i][0] <= sel_flit[i];
                        for (int s = 1; s < PIPE_STAGES; s++) begin
                            vld_q[i][s] <= vld_q[i][s-1];
                            if (vld_q[i][s-1]) dat_q[i][s] <= dat_q[i][s-1];
                        end
                    end
                end
            end
        end

        for (genvar i = 0; i < P; i++) begin : g_lane
            assign flit_out_all[i*Fw +: Fw] = dat_q[i][PIPE_STAGES-1];
            assign flit_out_we_all[i]       = vld_q[i][PIPE_STAGES-1] & ~out_stall[i];
        end
        assign overrun_ev = req & out_stall;
    end

    // Error set beats clear; counter clear beats increment
    always_comb begin
        conflict_d = (err_clr ? '0 : conflict_q) | multi;
        overrun_d  = (err_clr ? '0 : overrun_q) | overrun_ev;
        for (int i = 0; i < P; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (flit_out_we_all[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= '0;
            overrun_q  <= '0;
            for (int i = 0; i < P; i++) cnt_q[i] <= '0;
        end else begin
            conflict_q <= conflict_d;
            overrun_q  <= overrun_d;
            for (int i = 0; i < P; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign conflict_err = conflict_q;
    assign overrun_err  = overrun_q;
    assign cnt_out      = ({1'b0, cnt_sel} < (SELW+1)'(P)) ? cnt_q[cnt_sel] : '0;

endmodule
